// File: rtl/eclair_pkg.sv
// Shared control-store definitions: widths and the loader state encoding.
package eclair_pkg;

  localparam int unsigned CS_ADDR_WIDTH = 8;
  localparam int unsigned CS_DATA_WIDTH = 64;
  localparam int unsigned WAIT_WIDTH    = 4;

  typedef enum logic [2:0] {
    LD_IDLE,
    LD_READ,
    LD_WRITE,
    LD_VERIFY,
    LD_DONE,
    LD_FAIL
  } ld_state_e;

endpackage

// File: rtl/cs_loader_if.sv
// Control-store loader bus: sequencer/ROM/RAM side signals of the loader.
interface cs_loader_if import eclair_pkg::*; #(
  parameter int unsigned ADDR_WIDTH = CS_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = CS_DATA_WIDTH
);

  logic                  reload;
  logic [ADDR_WIDTH-1:0] seq_addr;
  logic [DATA_WIDTH-1:0] rom_data;
  logic [DATA_WIDTH-1:0] ram_rdata;
  logic [ADDR_WIDTH-1:0] cs_addr;
  logic [DATA_WIDTH-1:0] ram_wdata;
  logic                  ram_w_n;
  logic                  cs_ready;
  logic                  load_error;
  logic [ADDR_WIDTH-1:0] err_addr;

  modport master (
    input  reload, seq_addr, rom_data, ram_rdata,
    output cs_addr, ram_wdata, ram_w_n, cs_ready, load_error, err_addr
  );

  modport slave (
    output reload, seq_addr, rom_data, ram_rdata,
    input  cs_addr, ram_wdata, ram_w_n, cs_ready, load_error, err_addr
  );

endinterface

// File: rtl/cs_loader_counter.sv
// Up-counter with synchronous load; used as the control-store load address.
module cs_loader_counter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             en_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] count_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else if (load_i) begin
      count_q <= load_val_i;
    end else if (en_i) begin
      count_q <= count_q + WIDTH'(1);
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/cs_loader.sv
// Copies the microcode EPROM into control-store RAM word by word with readback
// verify, then hands the RAM address over to the sequencer.
module cs_loader import eclair_pkg::*; #(
  parameter int unsigned ADDR_WIDTH = CS_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = CS_DATA_WIDTH,
  parameter int unsigned ROM_WAIT   = 1
) (
  input logic        clk,
  input logic        reset,
  cs_loader_if.master bus
);

  localparam logic [WAIT_WIDTH-1:0] WAIT_LAST = WAIT_WIDTH'(ROM_WAIT - 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = '1;

  ld_state_e             state_q, state_d;
  logic [WAIT_WIDTH-1:0] wait_q, wait_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  ram_w_n_q, ram_w_n_d;
  logic                  cs_ready_q, cs_ready_d;
  logic                  load_error_q, load_error_d;
  logic [ADDR_WIDTH-1:0] err_addr_q, err_addr_d;
  logic                  cnt_load, cnt_en;
  logic [ADDR_WIDTH-1:0] load_addr;
  logic [ADDR_WIDTH-1:0] cs_addr_c;

  cs_loader_counter #(.WIDTH(ADDR_WIDTH)) u_addr_cnt (
    .clk        (clk),
    .reset      (reset),
    .load_i     (cnt_load),
    .load_val_i ('0),
    .en_i       (cnt_en),
    .count_o    (load_addr)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= LD_IDLE;
      wait_q       <= '0;
      wdata_q      <= '0;
      ram_w_n_q    <= 1'b1;
      cs_ready_q   <= 1'b0;
      load_error_q <= 1'b0;
      err_addr_q   <= '0;
    end else begin
      state_q      <= state_d;
      wait_q       <= wait_d;
      wdata_q      <= wdata_d;
      ram_w_n_q    <= ram_w_n_d;
      cs_ready_q   <= cs_ready_d;
      load_error_q <= load_error_d;
      err_addr_q   <= err_addr_d;
    end
  end

  // Next-state: READ(ROM_WAIT) -> WRITE(1) -> VERIFY(1) per word.
  always_comb begin
    state_d      = state_q;
    wait_d       = wait_q;
    wdata_d      = wdata_q;
    cs_ready_d   = cs_ready_q;
    load_error_d = load_error_q;
    err_addr_d   = err_addr_q;
    cnt_load     = 1'b0;
    cnt_en       = 1'b0;
    unique case (state_q)
      LD_IDLE: begin
        cnt_load = 1'b1;
        wait_d   = '0;
        state_d  = LD_READ;
      end
      LD_READ: begin
        if (wait_q == WAIT_LAST) begin
          wdata_d = bus.rom_data;
          wait_d  = '0;
          state_d = LD_WRITE;
        end else begin
          wait_d = wait_q + WAIT_WIDTH'(1);
        end
      end
      LD_WRITE: state_d = LD_VERIFY;
      LD_VERIFY: begin
        if (bus.ram_rdata != wdata_q) begin
          load_error_d = 1'b1;
          err_addr_d   = load_addr;
          state_d      = LD_FAIL;
        end else if (load_addr == ADDR_LAST) begin
          cs_ready_d = 1'b1;
          state_d    = LD_DONE;
        end else begin
          cnt_en  = 1'b1;
          state_d = LD_READ;
        end
      end
      LD_DONE: begin
        if (bus.reload) begin
          cs_ready_d = 1'b0;
          state_d    = LD_IDLE;
        end
      end
      LD_FAIL: begin
        if (bus.reload) begin
          load_error_d = 1'b0;
          state_d      = LD_IDLE;
        end
      end
      default: state_d = LD_IDLE;
    endcase
    // Strobe is registered so it is low for exactly the WRITE cycle.
    ram_w_n_d = (state_d != LD_WRITE);
  end

  always_comb begin
    unique case (state_q)
      LD_DONE: cs_addr_c = bus.seq_addr;
      LD_FAIL: cs_addr_c = err_addr_q;
      default: cs_addr_c = load_addr;
    endcase
  end

  assign bus.cs_addr    = cs_addr_c;
  assign bus.ram_wdata  = wdata_q;
  assign bus.ram_w_n    = ram_w_n_q;
  assign bus.cs_ready   = cs_ready_q;
  assign bus.load_error = load_error_q;
  assign bus.err_addr   = err_addr_q;

endmodule

// File: tb/tb_cs_loader.sv
// Scoreboard bench for cs_loader: expected RAM writes and ready/error events
// are queued by the driver and consumed by a negedge monitor.
module tb_cs_loader;

  localparam int unsigned AW = 8;
  localparam int unsigned DW = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, reset3, corrupt;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  cs_loader_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus1 ();
  cs_loader_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus3 ();

  cs_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ROM_WAIT(1)) dut (
    .clk(clk), .reset(reset), .bus(bus1)
  );
  cs_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ROM_WAIT(3)) dut3 (
    .clk(clk), .reset(reset3), .bus(bus3)
  );

  // ROM word[n] = {8{n}}; RAM ideal, optionally corrupting bit 5 at 0x42 on read
  logic [DW-1:0] mem1 [256];
  logic [DW-1:0] mem3 [256];
  assign bus1.rom_data  = {8{bus1.cs_addr}};
  assign bus3.rom_data  = {8{bus3.cs_addr}};
  assign bus1.ram_rdata = mem1[bus1.cs_addr] ^
                          ((corrupt && bus1.cs_addr == 8'h42) ? 64'h20 : 64'h0);
  assign bus3.ram_rdata = mem3[bus3.cs_addr];
  always @(posedge clk) if (!bus1.ram_w_n) mem1[bus1.cs_addr] <= bus1.ram_wdata;
  always @(posedge clk) if (!bus3.ram_w_n) mem3[bus3.cs_addr] <= bus3.ram_wdata;

  typedef struct {
    int            kind;   // 1 write, 2 ready rise, 3 error rise
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    int            cyc;
  } ev_t;

  ev_t exp_q[$];
  int  n_chk = 0;
  int  n_pass = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // rel: edge index such that edge rel+1 is the IDLE->READ edge
  task automatic push_load(input int rel, input int last, input bit fail);
    ev_t e;
    for (int k = 0; k <= last; k++) begin
      e.kind = 1;
      e.addr = AW'(k);
      e.data = {8{8'(k)}};
      e.cyc  = rel + 2 + 3 * k;
      exp_q.push_back(e);
    end
    e.kind = fail ? 3 : 2;
    e.addr = fail ? AW'(last) : '0;
    e.data = '0;
    e.cyc  = rel + 1 + (last + 1) * 3;
    exp_q.push_back(e);
  endtask

  task automatic observe(input int kind, input logic [AW-1:0] addr, input logic [DW-1:0] data);
    ev_t e;
    if (exp_q.size() == 0) begin
      chk("unexpected_event", 64'(kind), 64'(0));
    end else begin
      e = exp_q.pop_front();
      chk("ev_kind", 64'(kind), 64'(e.kind));
      if (kind == e.kind) begin
        if (kind != 2) chk("ev_addr", 64'(addr), 64'(e.addr));
        if (kind == 1) chk("ev_wdata", data, e.data);
        chk("ev_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
  endtask

  logic prev_rdy = 1'b0, prev_err = 1'b0;
  always @(negedge clk) begin
    if (!reset) begin
      if (!bus1.ram_w_n) observe(1, bus1.cs_addr, bus1.ram_wdata);
      if (bus1.cs_ready && !prev_rdy) observe(2, '0, '0);
      if (bus1.load_error && !prev_err) observe(3, bus1.err_addr, '0);
    end
    prev_rdy = bus1.cs_ready;
    prev_err = bus1.load_error;
  end

  // ROM_WAIT=3 instance: one-cycle strobes, address order, ready at edge 1281
  logic prev_wn3 = 1'b1, prev_rdy3 = 1'b0;
  int   wcnt3 = 0;
  int   rel3 = 0;
  bit   rdy3_seen = 1'b0;
  always @(negedge clk) begin
    if (!reset3) begin
      if (!bus3.ram_w_n) begin
        chk("w3_pulse_width", 64'(prev_wn3), 64'(1));
        chk("w3_addr", 64'(bus3.cs_addr), 64'(wcnt3));
        wcnt3++;
      end
      if (bus3.cs_ready && !prev_rdy3) begin
        chk("rdy3_cycle", 64'(cyc), 64'(rel3 + 1281));
        chk("w3_count", 64'(wcnt3), 64'(256));
        rdy3_seen = 1'b1;
      end
    end
    prev_wn3  = bus3.ram_w_n;
    prev_rdy3 = bus3.cs_ready;
  end

  task automatic wait_ready(input string name);
    int n = 0;
    while (!bus1.cs_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk(name, 64'(bus1.cs_ready), 64'(1));
  endtask

  task automatic check_image(input string name, input bit sel3);
    int bad = 0;
    for (int i = 0; i < 256; i++) begin
      if ((sel3 ? mem3[i] : mem1[i]) !== {8{8'(i)}}) bad++;
    end
    chk(name, 64'(bad), 64'(0));
  endtask

  initial begin
    int n;
    reset = 1'b1; reset3 = 1'b1; corrupt = 1'b0;
    bus1.reload = 1'b0; bus1.seq_addr = '0;
    bus3.reload = 1'b0; bus3.seq_addr = '0;
    repeat (3) @(negedge clk);
    chk("rst_cs_ready",   64'(bus1.cs_ready),   64'(0));
    chk("rst_load_error", 64'(bus1.load_error), 64'(0));
    chk("rst_ram_w_n",    64'(bus1.ram_w_n),    64'(1));
    chk("rst_err_addr",   64'(bus1.err_addr),   64'(0));
    chk("rst_ram_wdata",  bus1.ram_wdata,       64'(0));
    chk("rst_cs_addr",    64'(bus1.cs_addr),    64'(0));

    // Full load with reload held high throughout loading
    bus1.reload = 1'b1;
    reset = 1'b0; reset3 = 1'b0;
    rel3 = cyc;
    push_load(cyc, 255, 1'b0);
    repeat (600) @(negedge clk);
    bus1.reload = 1'b0;
    wait_ready("load_a_ready");
    check_image("ram_image_a", 1'b0);

    // DONE: cs_addr follows seq_addr, then reload restarts
    for (int a = 0; a < 256; a++) begin
      bus1.seq_addr = AW'(a);
      #1;
      chk("sweep_cs_addr", 64'(bus1.cs_addr), 64'(a));
      @(negedge clk);
    end
    bus1.reload = 1'b1;
    push_load(cyc + 1, 255, 1'b0);
    @(negedge clk);
    bus1.reload = 1'b0;
    chk("reload_clears_ready", 64'(bus1.cs_ready), 64'(0));
    wait_ready("load_b_ready");

    // Reset during the WRITE of 0x80
    bus1.reload = 1'b1;
    push_load(cyc + 1, 255, 1'b0);
    @(negedge clk);
    bus1.reload = 1'b0;
    n = 0;
    while (!(!bus1.ram_w_n && bus1.cs_addr == 8'h80) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("hit_write_80", 64'({bus1.ram_w_n, bus1.cs_addr}), 64'h080);
    #2 reset = 1'b1;
    #1;
    chk("async_ram_w_n",  64'(bus1.ram_w_n),  64'(1));
    chk("async_cs_ready", 64'(bus1.cs_ready), 64'(0));
    chk("async_cs_addr",  64'(bus1.cs_addr),  64'(0));
    chk("async_wdata",    bus1.ram_wdata,     64'(0));
    exp_q.delete();
    @(negedge clk);
    reset = 1'b0;
    push_load(cyc, 255, 1'b0);
    wait_ready("load_c_ready");

    // Readback corruption at 0x42
    @(negedge clk);
    reset = 1'b1;
    corrupt = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    push_load(cyc, 8'h42, 1'b1);
    n = 0;
    while (!bus1.load_error && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("fail_seen", 64'(bus1.load_error), 64'(1));
    repeat (40) @(negedge clk);
    chk("fail_error_held", 64'(bus1.load_error), 64'(1));
    chk("fail_ready_low",  64'(bus1.cs_ready),   64'(0));
    chk("fail_cs_addr",    64'(bus1.cs_addr),    64'h42);
    chk("fail_err_addr",   64'(bus1.err_addr),   64'h42);
    chk("fail_ram_w_n",    64'(bus1.ram_w_n),    64'(1));

    // Reload out of FAIL
    corrupt = 1'b0;
    bus1.reload = 1'b1;
    push_load(cyc + 1, 255, 1'b0);
    @(negedge clk);
    bus1.reload = 1'b0;
    chk("reload_clears_error", 64'(bus1.load_error), 64'(0));
    wait_ready("load_d_ready");
    check_image("ram_image_d", 1'b0);

    repeat (4) @(negedge clk);
    chk("queue_empty", 64'(exp_q.size()), 64'(0));
    chk("rdy3_seen", 64'(rdy3_seen), 64'(1));
    check_image("ram_image_w3", 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/cs_loader.md
CS_LOADER -- requirements
Module: cs_loader

Interface
REQ-001 Parameter ADDR_WIDTH, default 8, control store address width (depth 2^ADDR_WIDTH words).
REQ-002 Parameter DATA_WIDTH, default 64, microword width.
REQ-003 Parameter ROM_WAIT, default 1, ROM access wait cycles per word; legal values 1..15.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 reload  input  1  restart request, sampled only in DONE or FAIL.
REQ-007 seq_addr  input  ADDR_WIDTH  address from the microcode sequencer counter.
REQ-008 rom_data  input  DATA_WIDTH  microcode EPROM read data.
REQ-009 ram_rdata  input  DATA_WIDTH  control store RAM read data.
REQ-010 cs_addr  output  ADDR_WIDTH  address to ROM and RAM: load address while loading, seq_addr in DONE.
REQ-011 ram_wdata  output  DATA_WIDTH  latched ROM word to RAM.
REQ-012 ram_w_n  output  1  RAM write strobe, active-low, registered.
REQ-013 cs_ready  output  1  control store valid; gates the machine reset and the sequencer clock select.
REQ-014 load_error  output  1  readback mismatch detected.
REQ-015 err_addr  output  ADDR_WIDTH  address of the first mismatch.

Function
REQ-016 States: IDLE, READ, WRITE, VERIFY, DONE, FAIL.
REQ-017 IDLE: next edge goes to READ, load address = 0.
REQ-018 READ: exactly ROM_WAIT cycles; rom_data is captured into ram_wdata on the last READ edge.
REQ-019 WRITE: exactly 1 cycle; ram_w_n low for that whole cycle only; ram_wdata and cs_addr stable throughout.
REQ-020 VERIFY: exactly 1 cycle; ram_w_n high; ram_rdata compared with ram_wdata at the closing edge.
REQ-021 Mismatch: go to FAIL, set load_error, latch err_addr = load address.
REQ-022 Match and load address < 2^ADDR_WIDTH-1: increment address, go to READ.
REQ-023 Match and load address = all-ones: go to DONE; the address does not wrap, and no extra word is written.
REQ-024 Per-word cost is ROM_WAIT+2 cycles; cs_ready rises after edge 1 + 2^ADDR_WIDTH*(ROM_WAIT+2) following reset release (769 at defaults).
REQ-025 DONE: cs_ready=1, cs_addr = seq_addr combinationally, ram_w_n held high.
REQ-026 FAIL: cs_ready=0, load_error=1, cs_addr frozen at err_addr, halted until reload or reset.
REQ-027 reload=1 in DONE or FAIL: next state IDLE; cs_ready and load_error clear on that edge.
REQ-028 reload in IDLE/READ/WRITE/VERIFY is ignored.
REQ-029 At most one write per address per load pass; no write occurs outside WRITE.

Reset
REQ-030 reset asserted in any state, including mid-WRITE: state IDLE, load address 0, ram_w_n=1, cs_ready=0, load_error=0, err_addr=0, ram_wdata=0, all immediately (asynchronously).
REQ-031 After reset release, loading restarts from address 0 on the first edge; partially loaded RAM contents are simply overwritten.

Structure
REQ-032 Shared package eclair_pkg holds CS_ADDR_WIDTH=8, CS_DATA_WIDTH=64 and the loader state enum.
REQ-033 Load address uses one instance of the existing counter sub-module (WIDTH=ADDR_WIDTH, load/preset used for restart to 0).
REQ-034 cs_addr mux, compare and output registers live in cs_loader itself.

Verification
REQ-035 Reset release, ROM model word[n] = {8{n}}, ideal RAM model -> 256 writes in address order 0..255, cs_ready rises after edge 769, RAM matches ROM.
REQ-036 ROM_WAIT=3 -> ram_w_n low exactly 1 cycle per word, cs_ready after edge 1281.
REQ-037 RAM model corrupts bit 5 of address 0x42 -> FAIL, load_error=1, err_addr=0x42, no write at 0x43, cs_ready stays 0.
REQ-038 reset pulsed during the WRITE of address 0x80 -> ram_w_n rises immediately, reload completes from address 0, cs_ready after edge 769 from release.
REQ-039 In DONE, seq_addr swept 0x00..0xFF -> cs_addr tracks seq_addr, no writes; reload pulse -> cs_ready=0 next edge, full reload.
REQ-040 reload held high during loading -> no effect on sequence or timing.
